// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: operand/register widths and the common
// typedefs used by the register file, the operand mux and the ALU.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 4;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/rf_read_port.sv
// One registered read port of the register file. It picks between the
// R0 zero rule, write-first forwarding and the stored value, and holds
// its output when the port is not enabled.
module rf_read_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              is_r0_s;
  logic              fwd_hit_s;

  assign is_r0_s   = (ZERO_R0 != 0) && (raddr == {ADDR_W{1'b0}});
  assign fwd_hit_s = we && (raddr == waddr);

  // Next read value: R0 rule first, then same-cycle write, then storage.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (is_r0_s) begin
        rdata_d = {DATA_W{1'b0}};
      end else if (fwd_hit_s) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_rdata;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output flop; reset wins over any read launched in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : rf_read_port

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write general-purpose register file for the 8-bit CPU.
// Storage and write logic live here; each read port is a registered
// rf_read_port with write-first forwarding. Port A feeds operand mux
// in0, port B feeds in1.
module reg_file_2r1w #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_ok_s;
  logic [DATA_W-1:0] mem_rd_a_s;
  logic [DATA_W-1:0] mem_rd_b_s;

  // A write to R0 is dropped when R0 is hard-wired to zero.
  assign wr_ok_s = we && !((ZERO_R0 != 0) && (waddr == {ADDR_W{1'b0}}));

  // Next storage contents: copy current state, overlay the accepted write.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok_s) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  // Storage array; reset clears every register and discards the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign mem_rd_a_s = mem_q[raddr_a];
  assign mem_rd_b_s = mem_q[raddr_b];

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ZERO_R0(ZERO_R0)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .re       (re_a),
    .raddr    (raddr_a),
    .mem_rdata(mem_rd_a_s),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_a)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ZERO_R0(ZERO_R0)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .re       (re_b),
    .raddr    (raddr_b),
    .mem_rdata(mem_rd_b_s),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_b)
  );

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a plain build and a ZERO_R0 build share the
// same stimulus; a reference model per build pushes expected read data
// into queues as each cycle is driven, popped after the clock edge.
module tb_reg_file_2r1w;

  logic       clk;
  logic       rst;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       re_a;
  logic [1:0] raddr_a;
  logic       re_b;
  logic [1:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic [7:0] rdz_a;
  logic [7:0] rdz_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl   [4];
  logic [7:0] mdl_z [4];
  logic [7:0] h_a, h_b, hz_a, hz_b;
  logic [7:0] q_a[$], q_b[$], qz_a[$], qz_b[$];

  reg_file_2r1w #(.ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  reg_file_2r1w #(.ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdz_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdz_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict, then compare all four outputs after the edge.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [1:0] wa, input logic [7:0] wd,
                      input logic ea, input logic [1:0] a,
                      input logic eb, input logic [1:0] b);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = a; re_b = eb; raddr_b = b;
    if (r) begin
      h_a = 8'h00; h_b = 8'h00; hz_a = 8'h00; hz_b = 8'h00;
      for (int i = 0; i < 4; i++) begin
        mdl[i] = 8'h00; mdl_z[i] = 8'h00;
      end
    end else begin
      if (ea) begin
        h_a  = (w && wa == a) ? wd : mdl[a];
        hz_a = (a == 2'd0) ? 8'h00 : ((w && wa == a) ? wd : mdl_z[a]);
      end
      if (eb) begin
        h_b  = (w && wa == b) ? wd : mdl[b];
        hz_b = (b == 2'd0) ? 8'h00 : ((w && wa == b) ? wd : mdl_z[b]);
      end
      if (w) mdl[wa] = wd;
      if (w && wa != 2'd0) mdl_z[wa] = wd;
    end
    q_a.push_back(h_a); q_b.push_back(h_b);
    qz_a.push_back(hz_a); qz_b.push_back(hz_b);
    @(posedge clk);
    #1;
    check_val({tag, "/a"},  rdata_a, q_a.pop_front());
    check_val({tag, "/b"},  rdata_b, q_b.pop_front());
    check_val({tag, "/za"}, rdz_a,   qz_a.pop_front());
    check_val({tag, "/zb"}, rdz_b,   qz_b.pop_front());
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
    re_a = 1'b0; raddr_a = 2'd0; re_b = 1'b0; raddr_b = 2'd0;

    step("rst0", 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);
    step("rst1", 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);

    // Fill with FF, then reset with a read and write pending, then read back.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b0, 1'b1, 2'(i), 8'hFF, 1'b0, 2'd0, 1'b0, 2'd0);
    step("fill_rd", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 2'd2);
    step("rst_mid", 1'b1, 1'b1, 2'd1, 8'h77, 1'b1, 2'd1, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++)
      step("post_rst", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'(i), 1'b1, 2'(3 - i));

    // Write then read with one-cycle latency.
    step("wr_r2", 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd0);
    step("rd_r2", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0);

    // Write-first forwarding to both ports.
    step("wr_r1", 1'b0, 1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0);
    step("fwd_r1", 1'b0, 1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 1'b1, 2'd1);

    // Hold with re_b=0 across a write to the held register.
    step("wr_r3", 1'b0, 1'b1, 2'd3, 8'h55, 1'b0, 2'd0, 1'b0, 2'd0);
    step("rd_r3", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd3);
    step("hold_w", 1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3);
    step("hold_i", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3);
    step("rd_r3b", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd3);

    // Dual-port operands for the mux (R0 zero in the ZERO_R0 build).
    step("wr_r0", 1'b0, 1'b1, 2'd0, 8'hCC, 1'b0, 2'd0, 1'b0, 2'd0);
    step("wr_r1b", 1'b0, 1'b1, 2'd1, 8'h33, 1'b0, 2'd0, 1'b0, 2'd0);
    step("dual", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 2'd1);

    // R0 forwarding and read-back.
    step("fwd_r0", 1'b0, 1'b1, 2'd0, 8'hF0, 1'b1, 2'd0, 1'b1, 2'd0);
    step("rd_r0", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 2'd0);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom),
           8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file_2r1w

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 8-bit general-purpose register file for the 8-bit CPU datapath.
- Sits directly upstream of the 2:1 operand mux. Read port A drives the mux in0 and read port B drives the mux in1; the mux selects the ALU operand.
- Write port takes the ALU/writeback result.
- Reads are registered (1-cycle latency), with write-first forwarding, so a value written in one cycle is visible on a same-cycle read.

Parameters:
- DATA_W, 8, register width in bits; must match the operand mux width.
- NUM_REGS, 4, number of registers; must be a power of two, at least 2.
- ADDR_W, 2, address width, equal to log2(NUM_REGS). Derived; do not override independently.
- ZERO_R0, 0, when 1, R0 reads as 0 and writes to R0 are ignored.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_W  read index, port A.
- rdata_a  output  DATA_W  registered read data, port A; feeds operand mux in0.
- re_b  input  1  read enable, port B.
- raddr_b  input  ADDR_W  read index, port B.
- rdata_b  output  DATA_W  registered read data, port B; feeds operand mux in1.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All registers clear to 0; rdata_a = rdata_b = 0.
  - Reset has priority over we and re_x in the same cycle; no write occurs.
- Write:
  - On a rising edge with we=1 and rst=0, mem[waddr] <= wdata.
  - If ZERO_R0=1 and waddr=0, the write is dropped.
- Read latency is 1 cycle:
  - On a rising edge with re_x=1, rdata_x <= the value of mem[raddr_x] as of that edge.
  - With re_x=0, rdata_x holds its previous value, regardless of writes to the addressed register.
- Write-first forwarding: if we=1, re_x=1 and raddr_x==waddr in the same cycle, rdata_x <= wdata (the new value), not the old contents. The ZERO_R0 rule still applies: R0 forwards 0.
- Both ports may read the same address in the same cycle; both return identical data.
- Both ports are independent; there are no structural hazards and no stall output.
- Reset mid-operation: any pending read or write in the reset cycle is discarded. The first post-reset read of any register returns 0.
- Addresses are full-range (0..NUM_REGS-1); there are no out-of-range cases when NUM_REGS = 2^ADDR_W.
- No combinational path from any input to rdata_a or rdata_b; both outputs come directly from flops.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W = 8
  - REG_ADDR_W = 2
  - NUM_REGS = 4
  - reg_addr_t and data_t typedefs, used also by the operand mux and the ALU.
- One natural sub-module: rf_read_port, a registered read with enable, forwarding compare and the R0 zero rule. It is instantiated twice, for A and B.
- Storage array and write logic live in the top module.

Test Plan:
- Reset clears: write 8'hFF to all regs, assert rst for 1 cycle, then read R0..R3 on both ports → every read returns 8'h00 one cycle after re.
- Basic write/read latency: write R2=8'hA5 and deassert we; next cycle raddr_a=2, re_a=1 → rdata_a=8'hA5 exactly one edge later, not earlier.
- Forwarding: R1=8'h11, then in the same cycle we=1, waddr=1, wdata=8'h3C, re_a=re_b=1, raddr_a=raddr_b=1 → after that edge rdata_a=rdata_b=8'h3C.
- Hold on re=0: rdata_b=8'h55 from R3, then re_b=0 and write R3=8'h00 → rdata_b stays 8'h55 until re_b=1, then becomes 8'h00.
- Dual-port into mux: R0=8'hCC, R1=8'h33, raddr_a=0, raddr_b=1 → rdata_a=8'hCC and rdata_b=8'h33; operand mux out=8'hCC with sel=0 and 8'h33 with sel=1.
- ZERO_R0=1 build: write R0=8'hF0 → R0 reads 8'h00; a same-cycle forwarded read of R0 also returns 8'h00.
